tmr_toggle_decoder: RTL and testbench

Receive-side counterpart of the triplicated toggle-state FSM (out toggles each cycle its input is 1). Takes the three toggle lanes, majority-votes them and regenerates one single-cycle pulse per toggle. Flags lane disagreements, counts them, and marks lanes that stay in disagreement as faulty. Sits at the boundary where triplicated logic feeds a non-triplicated consumer.

---
 rtl/tmr_toggle_decoder.sv | 128 ++++++++++++
 tb/tb_tmr_toggle_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_toggle_decoder.sv
// tmr_toggle_decoder: receive side of a triplicated toggle FSM.
// Samples the three toggle lanes, majority-votes them, regenerates a
// single-cycle pulse per voted toggle, and tracks lane disagreement
// (registered mismatch flag, saturating mismatch counter, sticky per-lane
// fault flags after FAULT_LIMIT consecutive disagreeing samples).
// Optional build macro TMR_TOGGLE_DEC_SYNC_EN inserts a 2-flop synchronizer
// per lane ahead of the sample stage (latency 4 clk instead of 2).
module tmr_toggle_decoder #(
  parameter int CNT_W       = 8,
  parameter int FAULT_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inA,
  input  logic             inB,
  input  logic             inC,
  input  logic             clr,
  output logic             pulse,
  output logic             level,
  output logic             mismatch,
  output logic [CNT_W-1:0] mis_cnt,
  output logic             faultA,
  output logic             faultB,
  output logic             faultC
);

  // Run counters only ever need to reach FAULT_LIMIT (at most 255).
  localparam int                RUN_W   = 8;
  localparam logic [RUN_W-1:0]  LIMIT   = RUN_W'(FAULT_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [2:0]       lanes_in;
  logic [2:0]       samp_d;
  logic [2:0]       samp;
  logic             vote;
  logic             disagree;
  logic [2:0]       lane_off;
  logic [RUN_W-1:0] run     [3];
  logic [RUN_W-1:0] run_nxt [3];
  logic [2:0]       hit;
  logic [2:0]       fault;

  // Bit 0 = lane A, bit 1 = lane B, bit 2 = lane C.
  assign lanes_in = {inC, inB, inA};

`ifdef TMR_TOGGLE_DEC_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  // Two-flop synchronizer per lane for inputs from another clock domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= lanes_in;
      sync2 <= sync1;
    end
  end

  assign samp_d = sync2;
`else
  assign samp_d = lanes_in;
`endif

  // Sample stage: all voting and fault logic works on these registered lanes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samp <= '0;
    end else begin
      samp <= samp_d;
    end
  end

  // Majority vote and disagreement detection on the sampled lanes.
  always_comb begin
    vote     = (samp[0] & samp[1]) | (samp[1] & samp[2]) | (samp[0] & samp[2]);
    disagree = (samp != 3'b000) && (samp != 3'b111);
    lane_off = samp ^ {3{vote}};
  end

  // Next run length per lane: grows while the lane disagrees, capped at LIMIT.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      run_nxt[i] = '0;
      hit[i]     = 1'b0;
      if (lane_off[i]) begin
        run_nxt[i] = (run[i] >= LIMIT) ? LIMIT : run[i] + 1'b1;
      end
      hit[i] = (run_nxt[i] == LIMIT);
    end
  end

  // Voted level and toggle pulse; clr deliberately does not touch these.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level    <= 1'b0;
      pulse    <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      level    <= vote;
      pulse    <= vote ^ level;
      mismatch <= disagree;
    end
  end

  // Mismatch counter, run counters and sticky faults; clr wins over counting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mis_cnt <= '0;
      fault   <= '0;
      for (int i = 0; i < 3; i++) run[i] <= '0;
    end else if (clr) begin
      mis_cnt <= '0;
      fault   <= '0;
      for (int i = 0; i < 3; i++) run[i] <= '0;
    end else begin
      if (disagree && (mis_cnt != CNT_MAX)) mis_cnt <= mis_cnt + 1'b1;
      fault <= fault | hit;
      for (int i = 0; i < 3; i++) run[i] <= run_nxt[i];
    end
  end

  assign faultA = fault[0];
  assign faultB = fault[1];
  assign faultC = fault[2];

endmodule

// File: tb/tb_tmr_toggle_decoder.sv
// Bench for tmr_toggle_decoder: a default instance (CNT_W=8, FAULT_LIMIT=4)
// and a small one (CNT_W=2, FAULT_LIMIT=1) share the same lane stimulus.
// A delay-line reference model predicts every output after each clock edge.
module tb_tmr_toggle_decoder;

`ifdef TMR_TOGGLE_DEC_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn;
  logic inA, inB, inC, clr;
  always #5 clk = ~clk;

  logic       m_pulse, m_level, m_mis, m_fa, m_fb, m_fc;
  logic [7:0] m_cnt;
  logic       s_pulse, s_level, s_mis, s_fa, s_fb, s_fc;
  logic [1:0] s_cnt;

  tmr_toggle_decoder #(.CNT_W(8), .FAULT_LIMIT(4)) u_main (
    .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC), .clr(clr),
    .pulse(m_pulse), .level(m_level), .mismatch(m_mis), .mis_cnt(m_cnt),
    .faultA(m_fa), .faultB(m_fb), .faultC(m_fc)
  );

  tmr_toggle_decoder #(.CNT_W(2), .FAULT_LIMIT(1)) u_small (
    .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC), .clr(clr),
    .pulse(s_pulse), .level(s_level), .mismatch(s_mis), .mis_cnt(s_cnt),
    .faultA(s_fa), .faultB(s_fb), .faultC(s_fc)
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: lanes seen by the voter are the inputs from D+1 edges ago.
  logic [2:0] dly[$];
  bit         exp_level, exp_pulse, exp_mis;
  int         cnt   [2];
  int         run   [2][3];
  bit         fault [2][3];
  int         cmax  [2] = '{255, 3};
  int         flim  [2] = '{4, 1};

  task automatic model_reset();
    dly.delete();
    for (int i = 0; i <= D; i++) dly.push_front(3'b000);
    exp_level = 0; exp_pulse = 0; exp_mis = 0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0;
      for (int l = 0; l < 3; l++) begin run[k][l] = 0; fault[k][l] = 0; end
    end
  endtask

  task automatic model_step();
    logic [2:0] s;
    int         ones;
    bit         v;
    s    = dly[D];
    ones = int'(s[0]) + int'(s[1]) + int'(s[2]);
    v    = (ones >= 2);
    exp_pulse = (v != exp_level);
    exp_level = v;
    exp_mis   = (ones != 0) && (ones != 3);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        cnt[k] = 0;
        for (int l = 0; l < 3; l++) begin run[k][l] = 0; fault[k][l] = 0; end
      end else begin
        if (exp_mis && cnt[k] < cmax[k]) cnt[k]++;
        for (int l = 0; l < 3; l++) begin
          if (s[l] != v) run[k][l] = (run[k][l] + 1 > flim[k]) ? flim[k] : run[k][l] + 1;
          else run[k][l] = 0;
          if (run[k][l] == flim[k]) fault[k][l] = 1;
        end
      end
    end
    dly.push_front({inC, inB, inA});
    void'(dly.pop_back());
  endtask

  initial model_reset();
  always @(negedge rstn) model_reset();

  // Compare process: one step of the model and a full output check per edge.
  always @(posedge clk) begin
    #1;
    if (!rstn) model_reset();
    else model_step();
    chk("m_pulse", m_pulse, exp_pulse);
    chk("m_level", m_level, exp_level);
    chk("m_mismatch", m_mis, exp_mis);
    chk("m_mis_cnt", m_cnt, cnt[0]);
    chk("m_faultA", m_fa, fault[0][0]);
    chk("m_faultB", m_fb, fault[0][1]);
    chk("m_faultC", m_fc, fault[0][2]);
    chk("s_pulse", s_pulse, exp_pulse);
    chk("s_level", s_level, exp_level);
    chk("s_mismatch", s_mis, exp_mis);
    chk("s_mis_cnt", s_cnt, cnt[1]);
    chk("s_faultA", s_fa, fault[1][0]);
    chk("s_faultB", s_fb, fault[1][1]);
    chk("s_faultC", s_fc, fault[1][2]);
  end

  // Driver: set lanes/clr on the falling edge, return just after the next rising edge.
  task automatic cyc(input logic a, input logic b, input logic c, input logic cl);
    @(negedge clk);
    inA = a; inB = b; inC = c; clr = cl;
    @(posedge clk);
    #2;
  endtask

  int pulses;
  int base;
  int stuck_lane, stuck_len;
  bit stuck_val;
  logic [2:0] lv;

  initial begin
    rstn = 1'b0; inA = 0; inB = 0; inC = 0; clr = 0;
    repeat (3) @(negedge clk);
    chk("reset_pulse", m_pulse, 0);
    chk("reset_level", m_level, 0);
    chk("reset_mis_cnt", m_cnt, 0);
    chk("reset_faults", {m_fa, m_fb, m_fc}, 0);
    rstn = 1'b1;
    repeat (8) cyc(0, 0, 0, 0);

    // All lanes 0->1 together: pulse LAT edges later, once.
    for (int k = 1; k <= LAT + 1; k++) begin
      cyc(1, 1, 1, 0);
      chk("t1_pulse", m_pulse, (k == LAT));
      chk("t1_level", m_level, (k >= LAT));
      chk("t1_mismatch", m_mis, 0);
      chk("t1_mis_cnt", m_cnt, 0);
    end
    repeat (LAT + 2) cyc(0, 0, 0, 0);

    // Single-cycle glitch on lane B.
    for (int k = 1; k <= LAT + 2; k++) begin
      if (k == 1) cyc(0, 1, 0, 0); else cyc(0, 0, 0, 0);
      chk("t2_pulse", m_pulse, 0);
      chk("t2_mismatch", m_mis, (k == LAT));
      chk("t2_mis_cnt", m_cnt, (k >= LAT) ? 1 : 0);
      chk("t2_faultB", m_fb, 0);
    end

    // Lane C stuck at 1 for 6 cycles.
    cyc(0, 0, 0, 1);
    for (int k = 1; k <= LAT + 6; k++) begin
      cyc(0, 0, (k <= 6), 0);
      chk("t3_pulse", m_pulse, 0);
      chk("t3_faultC", m_fc, (k >= LAT + 3));
    end
    chk("t3_mis_cnt", m_cnt, 6);
    cyc(0, 0, 0, 1);
    chk("t3_clr_cnt", m_cnt, 0);
    chk("t3_clr_faultC", m_fc, 0);

    // Five mismatch cycles: small instance saturates at 3.
    repeat (5) cyc(1, 0, 0, 0);
    repeat (LAT) cyc(0, 0, 0, 0);
    chk("t4_main_cnt", m_cnt, 5);
    chk("t4_small_sat", s_cnt, 3);

    // Lanes A and B toggle, C stays 0: one real toggle.
    cyc(0, 0, 0, 1);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 0, 0);
      pulses += int'(m_pulse);
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_level", m_level, 1);
    chk("t5_mismatch", m_mis, 1);
    chk("t5_faultC", m_fc, 1);

    // Build faultA and mis_cnt=7, then reset asynchronously mid-cycle.
    repeat (LAT + 1) cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 1);
    repeat (LAT + 6) cyc(0, 1, 1, 0);
    chk("t6_pre_cnt", m_cnt, 7);
    chk("t6_pre_faultA", m_fa, 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_level", m_level, 0);
    chk("t6_rst_pulse", m_pulse, 0);
    chk("t6_rst_mismatch", m_mis, 0);
    chk("t6_rst_cnt", m_cnt, 0);
    chk("t6_rst_faults", {m_fa, m_fb, m_fc}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Randomized phase: voted toggles, lane glitches, stuck lanes, clr, resets.
    base = 0; stuck_len = 0; stuck_lane = 0; stuck_val = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) base ^= 1;
      lv = {3{base[0]}};
      for (int l = 0; l < 3; l++)
        if ($urandom_range(0, 9) == 0) lv[l] = ~lv[l];
      if (stuck_len == 0 && $urandom_range(0, 39) == 0) begin
        stuck_lane = $urandom_range(0, 2);
        stuck_val  = 1'($urandom_range(0, 1));
        stuck_len  = $urandom_range(1, 12);
      end
      if (stuck_len > 0) begin
        lv[stuck_lane] = stuck_val;
        stuck_len--;
      end
      inA = lv[0]; inB = lv[1]; inC = lv[2];
      clr = ($urandom_range(0, 63) == 0);
    end
    cyc(0, 0, 0, 0);
    repeat (LAT + 2) cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
